// File: rtl/moore_lamp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : moore_lamp_ctrl_pkg
// Purpose : Shared state width and state encoding for the two-lamp Moore
//           controller and its decoder.
// Contents: STATE_W, state_e (NINGUNA / UNA_SOLA / ILLEGAL / AMBAS)
// Revision: 1.0 - initial release
// ============================================================================
package moore_lamp_ctrl_pkg;

   localparam int STATE_W = 2;

   // {y1,y0}. ILLEGAL cannot be produced by the next-state equations.
   typedef enum logic [STATE_W-1:0] {
      ST_NINGUNA  = 2'b00,
      ST_UNA_SOLA = 2'b01,
      ST_ILLEGAL  = 2'b10,
      ST_AMBAS    = 2'b11
   } state_e;

endpackage : moore_lamp_ctrl_pkg
`default_nettype wire

// File: rtl/moore_lamp_ctrl_state_decoder_2to4.sv
`default_nettype none
// ============================================================================
// Module  : state_decoder_2to4
// Purpose : 2-to-4 one-hot decoder with enable. dec_o[i] is high when
//           sel_i == i and enable_i is high; all zero when disabled.
// Ports   : sel_i    [STATE_W-1:0] encoded state
//           enable_i               decoder enable
//           dec_o    [3:0]         one-hot decode
// Revision: 1.0 - initial release
// ============================================================================
module state_decoder_2to4
   import moore_lamp_ctrl_pkg::*;
(
   input  logic [STATE_W-1:0] sel_i,
   input  logic               enable_i,
   output logic [3:0]         dec_o
);

   always_comb begin
      dec_o = 4'b0000;
      if (enable_i) begin
         dec_o[sel_i] = 1'b1;
      end
   end

endmodule : state_decoder_2to4
`default_nettype wire

// File: rtl/moore_lamp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : moore_lamp_ctrl
// Purpose : Moore controller lighting none, one or both of two lamps from
//           the request pair {w1,w0}. In the single-lamp state the lit lamp
//           alternates on every fresh entry into that state.
// Ports   : Clk       system clock (rising edge)
//           reset     asynchronous active-high reset
//           w1, w0    request bits, synchronous to Clk
//           enable    decoder enable; low blanks all decoded/lamp outputs
//           state     current state {y1,y0}
//           ninguna   one-hot NINGUNA
//           una_sola  one-hot UNA_SOLA
//           ambas     one-hot AMBAS
//           b1, b2    lamp drives
// Revision: 1.0 - initial release
// ============================================================================
module moore_lamp_ctrl
   import moore_lamp_ctrl_pkg::*;
#(
   parameter logic Q_INIT = 1'b0
) (
   input  logic               Clk,
   input  logic               reset,
   input  logic               w1,
   input  logic               w0,
   input  logic               enable,
   output logic [STATE_W-1:0] state,
   output logic               ninguna,
   output logic               una_sola,
   output logic               ambas,
   output logic               b1,
   output logic               b2
);

   state_e     state_q;
   state_e     state_d;
   logic       q_q;
   logic       q_d;
   logic [3:0] dec;
   logic       dec_illegal_unused;

   // State register
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_NINGUNA;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state depends on the inputs only: Y1 = ~w1 & ~w0, Y0 = ~w1.
   // ILLEGAL falls out of these equations on the next edge.
   always_comb begin
      state_d = ST_NINGUNA;
      state_d = state_e'({~w1 & ~w0, ~w1});
   end

   // Alternation bit: flips only on entry into UNA_SOLA, so staying there
   // keeps the same lamp lit. Deliberately independent of enable.
   always_comb begin
      q_d = q_q;
      if ((state_d == ST_UNA_SOLA) && (state_q != ST_UNA_SOLA)) begin
         q_d = ~q_q;
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         q_q <= Q_INIT;
      end else begin
         q_q <= q_d;
      end
   end

   state_decoder_2to4 u_dec (
      .sel_i    (state_q),
      .enable_i (enable),
      .dec_o    (dec)
   );

   assign state              = state_q;
   assign ninguna            = dec[ST_NINGUNA];
   assign una_sola           = dec[ST_UNA_SOLA];
   assign ambas              = dec[ST_AMBAS];
   assign dec_illegal_unused = dec[ST_ILLEGAL];

   // una_sola is already gated by enable, so with enable low both lamps
   // fall back to ambas, which is also zero.
   assign b1 = una_sola ?  q_q : ambas;
   assign b2 = una_sola ? ~q_q : ambas;

endmodule : moore_lamp_ctrl
`default_nettype wire

// File: tb/tb_moore_lamp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_moore_lamp_ctrl
// Purpose : Self-checking bench for moore_lamp_ctrl. A behavioural model
//           tracks the lamp situation (how many lamps requested, which one
//           is next in the single-lamp case) and every output is compared
//           against it after each rising edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_moore_lamp_ctrl;

   logic       Clk;
   logic       reset;
   logic       w1;
   logic       w0;
   logic       enable;
   logic [1:0] state;
   logic       ninguna;
   logic       una_sola;
   logic       ambas;
   logic       b1;
   logic       b2;

   int checks;
   int errors;

   // Model: number of lamps lit (0, 1 or 2) and which lamp is lit when one.
   int m_lamps;
   bit m_first_is_b1;

   moore_lamp_ctrl #(.Q_INIT(1'b0)) dut (
      .Clk      (Clk),
      .reset    (reset),
      .w1       (w1),
      .w0       (w0),
      .enable   (enable),
      .state    (state),
      .ninguna  (ninguna),
      .una_sola (una_sola),
      .ambas    (ambas),
      .b1       (b1),
      .b2       (b2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   task automatic check_all(input string tag);
      logic [1:0] e_state;
      logic       e_b1, e_b2;
      e_state = (m_lamps == 0) ? 2'b00 : (m_lamps == 1) ? 2'b01 : 2'b11;
      if (!enable)           begin e_b1 = 1'b0; e_b2 = 1'b0; end
      else if (m_lamps == 2) begin e_b1 = 1'b1; e_b2 = 1'b1; end
      else if (m_lamps == 1) begin e_b1 = m_first_is_b1; e_b2 = !m_first_is_b1; end
      else                   begin e_b1 = 1'b0; e_b2 = 1'b0; end
      chk({tag, ".state"},    state, e_state);
      chk({tag, ".ninguna"},  {1'b0, ninguna},  {1'b0, enable && m_lamps == 0});
      chk({tag, ".una_sola"}, {1'b0, una_sola}, {1'b0, enable && m_lamps == 1});
      chk({tag, ".ambas"},    {1'b0, ambas},    {1'b0, enable && m_lamps == 2});
      chk({tag, ".b1b2"},     {b1, b2},         {e_b1, e_b2});
   endtask

   // Requests: w1 set -> no lamps; only w0 -> one lamp; none -> both lamps.
   task automatic model_edge();
      int nxt;
      nxt = w1 ? 0 : (w0 ? 1 : 2);
      if (nxt == 1 && m_lamps != 1) m_first_is_b1 = !m_first_is_b1;
      m_lamps = nxt;
   endtask

   task automatic step(input string tag);
      @(posedge Clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic apply(input logic a1, input logic a0);
      w1 = a1;
      w0 = a0;
   endtask

   initial begin
      logic [1:0] hold_b;
      checks = 0;
      errors = 0;
      m_lamps = 0;
      m_first_is_b1 = 1'b0;
      reset  = 1'b1;
      enable = 1'b1;
      w1 = 1'b0;
      w0 = 1'b0;

      // Reset before any clock edge
      #2;
      check_all("reset");
      #5;
      reset = 1'b0;
      step("first_edge");            // w=00 -> both lamps

      // Directed sequence, each request held two clocks
      apply(0, 1); step("seq01a"); step("seq01b");
      apply(1, 1); step("seq11a"); step("seq11b");
      apply(0, 0); step("seq00a"); step("seq00b");
      apply(0, 1); step("seq01c"); step("seq01d");
      apply(0, 0); step("seq00c"); step("seq00d");
      apply(0, 1); step("seq01e"); step("seq01f");
      chk("seq_end.b1b2", {b1, b2}, 2'b10);

      // Long hold in single-lamp state: lamp choice must stay put
      hold_b = {b1, b2};
      for (int i = 0; i < 10; i++) begin
         step("hold01");
         chk("hold01.const", {b1, b2}, hold_b);
      end

      // Disable: outputs blanked while state and alternation keep moving
      enable = 1'b0;
      #1; check_all("dis_now");
      apply(0, 0); step("dis00");
      apply(0, 1); step("dis01");
      apply(1, 0); step("dis10");
      apply(0, 1); step("dis01b");
      enable = 1'b1;
      #1; check_all("reenable");

      // Asynchronous reset in the middle of a cycle while in UNA_SOLA
      apply(0, 0); step("pre_rst00");
      apply(0, 1); step("pre_rst01");
      #2;
      reset = 1'b1;
      m_lamps = 0;
      m_first_is_b1 = 1'b0;
      #1; check_all("async_rst");
      #1;
      reset = 1'b0;
      step("post_rst");              // w=01 -> first entry after reset: b1
      chk("post_rst.b1b2", {b1, b2}, 2'b10);

      // Late input change shortly before an edge: no output movement
      // until the edge, then the new request is taken.
      for (int i = 0; i < 6; i++) begin
         hold_b = {b1, b2};
         #7;
         apply(i[0], i[1]);
         #1;
         chk("late.no_glitch", {b1, b2}, hold_b);
         check_all("late.before_edge");
         step("late.at_edge");
      end

      // Randomized traffic against the model
      for (int i = 0; i < 200; i++) begin
         apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         enable = ($urandom_range(0, 7) != 0);
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_moore_lamp_ctrl
`default_nettype wire
